reg_rename_file: RTL and testbench
==================================

Name: reg_rename_file

Overview:
- Architectural register file plus per-register rename tags (RoB ids). Sits directly downstream of the reorder buffer.
- Consumes its issue strobe (rd to RoB id binding) and its commit strobe (rd/value/RoB id writeback).
- Serves the decoder with two source-operand lookups: value if architecturally current, else producing RoB id.
- A flush drops all pending tags; committed values are retained.

Parameters:
- NREG, 32, number of architectural registers (x0 hardwired zero).
- XLEN, 32, data width.
- ROB_ADDR, 4, RoB id width; must equal the shared RoB address constant.

Ports:
- clk_in  input  1  clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global stall; when 0 no state changes.
- clear  input  1  flush from RoB (mispredict/jalr).
- issue_valid  input  1  RoB allocating an entry that writes rd.
- issue_rd  input  5  destination register of issued instruction.
- issue_robid  input  ROB_ADDR  RoB entry allocated.
- commit_valid  input  1  RoB committing an rd-writing entry.
- commit_rd  input  5  destination register of committed instruction.
- commit_robid  input  ROB_ADDR  RoB entry being committed.
- commit_value  input  XLEN  result written back.
- rs1  input  5  decoder source 1 index.
- rs2  input  5  decoder source 2 index.
- rs1_busy  output  1  1 = operand pending on rs1_dep.
- rs1_dep  output  ROB_ADDR  producing RoB id (0 when not busy).
- rs1_value  output  XLEN  architectural value (0 when busy).
- rs2_busy, rs2_dep, rs2_value  output  1/ROB_ADDR/XLEN  same for rs2.

Behaviour:
- State: value[NREG] (XLEN), busy[NREG] (1), dep[NREG] (ROB_ADDR). No registered outputs; all lookup outputs are combinational.
- Reset (rst_in=0, asynchronous): all value, busy and dep cleared to 0. Outputs therefore read busy=0, dep=0, value=0.
- rdy_in=0: hold all state; lookups remain valid.
- Commit (posedge, rdy_in, commit_valid, commit_rd!=0):
  - value[commit_rd] <= commit_value, always.
  - If busy[commit_rd] and dep[commit_rd]==commit_robid, set busy <= 0 and dep <= 0.
  - Otherwise the tag is untouched, because a younger producer owns the register.
- Issue (posedge, rdy_in, issue_valid, issue_rd!=0, !clear): busy[issue_rd] <= 1, dep[issue_rd] <= issue_robid.
- Same cycle, same register: issue overrides the commit tag-clear (the new producer wins). The commit value write still happens.
- Clear (posedge, rdy_in, clear): every busy <= 0 and dep <= 0. The commit in the same cycle still writes its value. Issue in the same cycle is ignored.
- x0: never written, never busy. Lookups of rs=0 return busy=0, dep=0, value=0 regardless of inputs.
- Lookup bypass (combinational, per port):
  - If commit_valid and rdy_in and commit_rd==rs!=0 and busy[rs] and dep[rs]==commit_robid: return busy=0, value=commit_value.
  - Otherwise return the stored busy/dep/value.
  - Issue in the same cycle is NOT reflected; the decoder handles intra-cycle dependence itself.
- RoB id 0 is a legal tag; busy, not dep!=0, qualifies pending.
- Latency: issue/commit visible to lookups the cycle after the edge (except the commit bypass above).

Decomposition:
- Shared constants header (existing): RoB address width, register count, XLEN.
- No typedefs needed. Single module; no sub-module is warranted.

Test Plan:
- Reset: drive rst_in=0 mid-run with x5 busy. Response: asynchronously rs1=5 reads busy=0, value=0, with no clock edge needed.
- Issue then commit: issue rd=5 id=3; next cycle rs1=5 gives busy=1, dep=3. Commit rd=5 id=3 value=0xDEADBEEF; in the same cycle the bypass gives busy=0, value=0xDEADBEEF; after the edge the stored value is 0xDEADBEEF.
- Stale commit: issue rd=7 id=2, then issue rd=7 id=4, then commit rd=7 id=2 value=0x11. Result: value=0x11, busy=1, dep=4. No bypass on rs2=7.
- Simultaneous issue/commit on same rd: busy rd=9 id=1; commit rd=9 id=1 value=0x55 with issue rd=9 id=6 in the same cycle. After the edge: busy=1, dep=6, value=0x55.
- Clear: x3, x4 busy; clear=1 with commit rd=3 value=0x22 and issue rd=8. After the edge: all busy=0, x3=0x22, x8 not busy.
- x0 and stall: issue rd=0 and commit rd=0 value=0x99 give rs1=0 reading 0, not busy. With rdy_in=0, issue rd=5 leaves x5 unchanged.

Source files
------------

// File: rtl/reg_rename_file_pkg.sv
// Shared constants for the architectural register file / rename tag block.
// ROB address width must track the reorder buffer's own constant.
package reg_rename_file_pkg;

    localparam int RRF_ROB_ADDR = 4;
    localparam int RRF_NREG     = 32;
    localparam int RRF_XLEN     = 32;
    localparam int RRF_REG_W    = 5;

    // x0 is hardwired, so a write strobe only counts for a non-zero rd.
    function automatic logic rrf_wr_en(input logic vld, input logic [RRF_REG_W-1:0] rd);
        return vld && (rd != '0);
    endfunction

endpackage

// File: rtl/reg_rename_file_if.sv
// RoB/decoder-facing bundle for reg_rename_file: issue, commit, flush,
// stall and the two source-operand lookup ports.
interface reg_rename_file_if
    import reg_rename_file_pkg::*;
#(
    parameter int ROB_ADDR = RRF_ROB_ADDR,
    parameter int XLEN     = RRF_XLEN
) ();

    logic                 rdy_in;
    logic                 clear;

    logic                 issue_valid;
    logic [RRF_REG_W-1:0] issue_rd;
    logic [ROB_ADDR-1:0]  issue_robid;

    logic                 commit_valid;
    logic [RRF_REG_W-1:0] commit_rd;
    logic [ROB_ADDR-1:0]  commit_robid;
    logic [XLEN-1:0]      commit_value;

    logic [RRF_REG_W-1:0] rs1;
    logic [RRF_REG_W-1:0] rs2;

    logic                 rs1_busy;
    logic [ROB_ADDR-1:0]  rs1_dep;
    logic [XLEN-1:0]      rs1_value;
    logic                 rs2_busy;
    logic [ROB_ADDR-1:0]  rs2_dep;
    logic [XLEN-1:0]      rs2_value;

    modport master (
        output rdy_in, clear,
        output issue_valid, issue_rd, issue_robid,
        output commit_valid, commit_rd, commit_robid, commit_value,
        output rs1, rs2,
        input  rs1_busy, rs1_dep, rs1_value,
        input  rs2_busy, rs2_dep, rs2_value
    );

    modport slave (
        input  rdy_in, clear,
        input  issue_valid, issue_rd, issue_robid,
        input  commit_valid, commit_rd, commit_robid, commit_value,
        input  rs1, rs2,
        output rs1_busy, rs1_dep, rs1_value,
        output rs2_busy, rs2_dep, rs2_value
    );

endinterface

// File: rtl/reg_rename_file.sv
// Architectural register file with per-register rename tags (RoB ids).
// Lookups are combinational, with a bypass for a commit that retires the current owner.
module reg_rename_file
    import reg_rename_file_pkg::*;
#(
    parameter int NREG     = RRF_NREG,
    parameter int XLEN     = RRF_XLEN,
    parameter int ROB_ADDR = RRF_ROB_ADDR
) (
    input  logic               clk_in,
    input  logic               rst_in,
    reg_rename_file_if.slave   bus
);

    localparam int NPORT = 2;

    logic [NREG-1:0][XLEN-1:0]     r_value;
    logic [NREG-1:0]               r_busy;
    logic [NREG-1:0][ROB_ADDR-1:0] r_dep;

    logic w_cmt_wr;
    logic w_cmt_hit;
    logic w_iss_wr;

    assign w_cmt_wr  = rrf_wr_en(bus.commit_valid, bus.commit_rd);
    assign w_iss_wr  = rrf_wr_en(bus.issue_valid, bus.issue_rd) && !bus.clear;
    // Only the owning producer may release the tag; a stale commit just lands its value.
    assign w_cmt_hit = w_cmt_wr && r_busy[bus.commit_rd]
                       && (r_dep[bus.commit_rd] == bus.commit_robid);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_value <= '0;
            r_busy  <= '0;
            r_dep   <= '0;
        end else if (bus.rdy_in) begin
            if (w_cmt_wr)
                r_value[bus.commit_rd] <= bus.commit_value;
            if (bus.clear) begin
                r_busy <= '0;
                r_dep  <= '0;
            end else begin
                if (w_cmt_hit) begin
                    r_busy[bus.commit_rd] <= 1'b0;
                    r_dep[bus.commit_rd]  <= '0;
                end
                // Later assignment wins: a same-cycle issue to rd re-tags it.
                if (w_iss_wr) begin
                    r_busy[bus.issue_rd] <= 1'b1;
                    r_dep[bus.issue_rd]  <= bus.issue_robid;
                end
            end
        end
    end

    logic [NPORT-1:0][RRF_REG_W-1:0] w_rs;
    logic [NPORT-1:0]                w_rs_busy;
    logic [NPORT-1:0][ROB_ADDR-1:0]  w_rs_dep;
    logic [NPORT-1:0][XLEN-1:0]      w_rs_value;

    assign w_rs[0] = bus.rs1;
    assign w_rs[1] = bus.rs2;

    for (genvar p = 0; p < NPORT; p++) begin : g_lookup
        logic w_nz;
        logic w_byp;
        assign w_nz  = (w_rs[p] != '0);
        // w_cmt_hit already excludes x0, so the bypass never fires for rs=0.
        assign w_byp = w_cmt_hit && bus.rdy_in && (bus.commit_rd == w_rs[p]);

        assign w_rs_busy[p]  = w_nz && r_busy[w_rs[p]] && !w_byp;
        assign w_rs_dep[p]   = w_rs_busy[p] ? r_dep[w_rs[p]] : '0;
        assign w_rs_value[p] = w_byp                   ? bus.commit_value :
                               (w_rs_busy[p] || !w_nz) ? '0 : r_value[w_rs[p]];
    end

    assign bus.rs1_busy  = w_rs_busy[0];
    assign bus.rs1_dep   = w_rs_dep[0];
    assign bus.rs1_value = w_rs_value[0];
    assign bus.rs2_busy  = w_rs_busy[1];
    assign bus.rs2_dep   = w_rs_dep[1];
    assign bus.rs2_value = w_rs_value[1];

endmodule

// File: tb/tb_reg_rename_file.sv
// Directed scenarios plus randomized traffic against an owner-tracking model.
module tb_reg_rename_file;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;
    always #5 clk_in = ~clk_in;

    reg_rename_file_if bus ();

    reg_rename_file dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // Model: committed value per register and the RoB id that currently owns it (-1 = none).
    logic [31:0] m_val   [32];
    int          m_owner [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]   = '0;
            m_owner[i] = -1;
        end
    endtask

    task automatic idle();
        bus.rdy_in       = 1'b1;
        bus.clear        = 1'b0;
        bus.issue_valid  = 1'b0;
        bus.issue_rd     = '0;
        bus.issue_robid  = '0;
        bus.commit_valid = 1'b0;
        bus.commit_rd    = '0;
        bus.commit_robid = '0;
        bus.commit_value = '0;
        bus.rs1          = '0;
        bus.rs2          = '0;
    endtask

    task automatic iss(input int rd, input int id);
        bus.issue_valid = 1'b1;
        bus.issue_rd    = 5'(rd);
        bus.issue_robid = 4'(id);
    endtask

    task automatic cmt(input int rd, input int id, input logic [31:0] v);
        bus.commit_valid = 1'b1;
        bus.commit_rd    = 5'(rd);
        bus.commit_robid = 4'(id);
        bus.commit_value = v;
    endtask

    function automatic void exp_lookup(input logic [4:0] rs, output logic b,
                                       output logic [3:0] d, output logic [31:0] v);
        int r;
        r = int'(rs);
        b = 1'b0; d = '0; v = '0;
        if (r == 0) return;
        if (bus.rdy_in && bus.commit_valid && int'(bus.commit_rd) == r
            && m_owner[r] == int'(bus.commit_robid)) begin
            v = bus.commit_value;
        end else if (m_owner[r] >= 0) begin
            b = 1'b1;
            d = 4'(m_owner[r]);
        end else begin
            v = m_val[r];
        end
    endfunction

    task automatic check_lookups(input string tag);
        logic b; logic [3:0] d; logic [31:0] v;
        exp_lookup(bus.rs1, b, d, v);
        chk({tag, ".rs1_busy"},  32'(bus.rs1_busy),  32'(b));
        chk({tag, ".rs1_dep"},   32'(bus.rs1_dep),   32'(d));
        chk({tag, ".rs1_value"}, bus.rs1_value,      v);
        exp_lookup(bus.rs2, b, d, v);
        chk({tag, ".rs2_busy"},  32'(bus.rs2_busy),  32'(b));
        chk({tag, ".rs2_dep"},   32'(bus.rs2_dep),   32'(d));
        chk({tag, ".rs2_value"}, bus.rs2_value,      v);
    endtask

    task automatic model_update();
        int crd, ird;
        crd = int'(bus.commit_rd);
        ird = int'(bus.issue_rd);
        if (!bus.rdy_in) return;
        if (bus.clear) begin
            for (int i = 0; i < 32; i++) m_owner[i] = -1;
        end else if (bus.commit_valid && crd != 0 && m_owner[crd] == int'(bus.commit_robid)) begin
            m_owner[crd] = -1;
        end
        if (bus.commit_valid && crd != 0) m_val[crd] = bus.commit_value;
        if (!bus.clear && bus.issue_valid && ird != 0) m_owner[ird] = int'(bus.issue_robid);
    endtask

    // Inputs are driven at negedge; check, advance the model, cross the posedge.
    task automatic tick(input string tag);
        #1 check_lookups(tag);
        model_update();
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    initial begin
        idle();
        model_reset();
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;

        // Reset state
        idle(); bus.rs1 = 5'd5; bus.rs2 = 5'd31;
        #1 chk("rst_busy", 32'(bus.rs1_busy), 32'd0);
        chk("rst_value", bus.rs2_value, 32'd0);
        tick("rst");

        // Issue then commit with bypass
        idle(); iss(5, 3); tick("iss5");
        idle(); bus.rs1 = 5'd5;
        #1 chk("iss_busy", 32'(bus.rs1_busy), 32'd1);
        chk("iss_dep", 32'(bus.rs1_dep), 32'd3);
        tick("iss5_rd");
        idle(); cmt(5, 3, 32'hDEADBEEF); bus.rs1 = 5'd5;
        #1 chk("byp_busy", 32'(bus.rs1_busy), 32'd0);
        chk("byp_value", bus.rs1_value, 32'hDEADBEEF);
        tick("cmt5");
        idle(); bus.rs1 = 5'd5;
        #1 chk("cmt_value", bus.rs1_value, 32'hDEADBEEF);
        tick("cmt5_rd");

        // Stale commit
        idle(); iss(7, 2); tick("iss7a");
        idle(); iss(7, 4); tick("iss7b");
        idle(); cmt(7, 2, 32'h11); bus.rs2 = 5'd7;
        #1 chk("stale_nobyp", 32'(bus.rs2_busy), 32'd1);
        tick("stale");
        idle(); bus.rs2 = 5'd7;
        #1 chk("stale_dep", 32'(bus.rs2_dep), 32'd4);
        tick("stale_rd");

        // Simultaneous issue/commit on same rd
        idle(); iss(9, 1); tick("iss9");
        idle(); cmt(9, 1, 32'h55); iss(9, 6); bus.rs1 = 5'd9; tick("sim9");
        idle(); bus.rs1 = 5'd9;
        #1 chk("sim_busy", 32'(bus.rs1_busy), 32'd1);
        chk("sim_dep", 32'(bus.rs1_dep), 32'd6);
        tick("sim9_rd");

        // Clear with same-cycle commit and issue
        idle(); iss(3, 1); tick("iss3");
        idle(); iss(4, 2); tick("iss4");
        idle(); bus.clear = 1'b1; cmt(3, 1, 32'h22); iss(8, 7); tick("clr");
        idle(); bus.rs1 = 5'd3; bus.rs2 = 5'd4;
        #1 chk("clr_x3_val", bus.rs1_value, 32'h22);
        chk("clr_x4_busy", 32'(bus.rs2_busy), 32'd0);
        tick("clr_rd");
        idle(); bus.rs1 = 5'd8; bus.rs2 = 5'd7;
        #1 chk("clr_x8_busy", 32'(bus.rs1_busy), 32'd0);
        chk("clr_x7_val", bus.rs2_value, 32'h11);
        tick("clr_rd2");
        idle(); bus.rs1 = 5'd9;
        #1 chk("clr_x9_val", bus.rs1_value, 32'h55);
        tick("clr_rd3");

        // x0 and stall
        idle(); iss(0, 5); cmt(0, 0, 32'h99); bus.rs1 = 5'd0; tick("x0");
        idle(); bus.rs1 = 5'd0;
        #1 chk("x0_value", bus.rs1_value, 32'd0);
        chk("x0_busy", 32'(bus.rs1_busy), 32'd0);
        tick("x0_rd");
        idle(); bus.rdy_in = 1'b0; iss(5, 9); cmt(5, 0, 32'h77); tick("stall");
        idle(); bus.rs1 = 5'd5;
        #1 chk("stall_busy", 32'(bus.rs1_busy), 32'd0);
        chk("stall_value", bus.rs1_value, 32'hDEADBEEF);
        tick("stall_rd");

        // Asynchronous reset mid-run with x5 busy
        idle(); iss(5, 2); tick("iss5r");
        idle(); bus.rs1 = 5'd5;
        #1 chk("prerst_busy", 32'(bus.rs1_busy), 32'd1);
        #1 rst_in = 1'b0;
        #1 chk("arst_busy", 32'(bus.rs1_busy), 32'd0);
        chk("arst_value", bus.rs1_value, 32'd0);
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b1;

        // Randomized traffic on a small register window to force collisions
        for (int n = 0; n < 600; n++) begin
            int crd;
            idle();
            bus.rdy_in = ($urandom_range(0, 9) != 0);
            bus.clear  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 1) == 1) iss($urandom_range(0, 7), $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                crd = $urandom_range(0, 7);
                if (m_owner[crd] >= 0 && $urandom_range(0, 3) != 0)
                    cmt(crd, m_owner[crd], $urandom);
                else
                    cmt(crd, $urandom_range(0, 15), $urandom);
            end
            bus.rs1 = 5'($urandom_range(0, 7));
            bus.rs2 = 5'($urandom_range(0, 7));
            tick("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
